// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text-buffer reader: FSM state
// encoding, character/word geometry and a little-endian byte selector.
package lcd_pkg;

  localparam int CHAR_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = CHAR_W * BYTES_PER_WORD;
  localparam int IDX_W          = 2;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_LEN_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Byte 0 is the least significant byte of the RAM word.
  function automatic logic [CHAR_W-1:0] byte_sel(input logic [WORD_W-1:0] word,
                                                 input logic [IDX_W-1:0]  idx);
    logic [CHAR_W-1:0] sel_s;
    case (idx)
      2'd0:    sel_s = word[7:0];
      2'd1:    sel_s = word[15:8];
      2'd2:    sel_s = word[23:16];
      2'd3:    sel_s = word[31:24];
      default: sel_s = 8'h00;
    endcase
    return sel_s;
  endfunction

endpackage

// File: rtl/lcd_word_unpacker.sv
// Holds the fetched RAM word and streams its bytes out over valid/ready,
// tracking how many characters of the transfer remain.
module lcd_word_unpacker
  import lcd_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [LEN_W-1:0]  init_len,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic              char_ready,
  output logic [CHAR_W-1:0] char_data,
  output logic              char_valid,
  output logic              char_last,
  output logic              accept,
  output logic              word_end,
  output logic              xfer_end
);

  logic [WORD_W-1:0] word_r;
  logic [IDX_W-1:0]  idx_r;
  logic [LEN_W-1:0]  rem_r;
  logic              valid_r;
  logic              accept_s;

  assign accept_s   = valid_r & char_ready;
  assign accept     = accept_s;
  assign word_end   = (idx_r == 2'd3);
  assign xfer_end   = (rem_r == LEN_W'(1));
  assign char_data  = byte_sel(word_r, idx_r);
  assign char_valid = valid_r;
  assign char_last  = valid_r & (rem_r == LEN_W'(1));

  // Word capture, byte index, remaining count and output-valid register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_r  <= {WORD_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      rem_r   <= {LEN_W{1'b0}};
      valid_r <= 1'b0;
    end else begin
      if (init) begin
        rem_r <= init_len;
      end else if (accept_s) begin
        rem_r <= rem_r - LEN_W'(1);
      end else begin
        rem_r <= rem_r;
      end

      if (load) begin
        word_r  <= load_word;
        idx_r   <= {IDX_W{1'b0}};
        valid_r <= 1'b1;
      end else if (accept_s) begin
        idx_r <= idx_r + IDX_W'(1);
        // The word is exhausted or the transfer is over: drop valid so the
        // FSM can refetch or finish without exposing a stale byte.
        if ((idx_r == 2'd3) || (rem_r == LEN_W'(1))) begin
          valid_r <= 1'b0;
        end else begin
          valid_r <= 1'b1;
        end
      end else begin
        valid_r <= valid_r;
      end
    end
  end

endmodule

// File: rtl/lcd_text_reader.sv
// Avalon-MM read master over the text-buffer RAM: fetches one word at a time
// and hands characters to the LCD writer through lcd_word_unpacker.
module lcd_text_reader
  import lcd_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  input  logic [WORD_W-1:0] mem_readdata,
  output logic [CHAR_W-1:0] char_data,
  output logic              char_valid,
  output logic              char_last,
  input  logic              char_ready
);

  state_e            state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic              init_s;
  logic              load_s;
  logic              accept_s;
  logic              word_end_s;
  logic              xfer_end_s;

  assign init_s = (state_r == ST_IDLE) & start;
  assign load_s = (state_r == ST_WAIT);

  assign busy           = (state_r == ST_FETCH) | (state_r == ST_WAIT) | (state_r == ST_EMIT);
  assign done           = (state_r == ST_DONE);
  assign mem_address    = ptr_r;
  assign mem_chipselect = (state_r == ST_FETCH);
  assign mem_clken      = (state_r == ST_FETCH);
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;

  // Transfer sequencing and word pointer; the pointer wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            ptr_r   <= base_addr;
            state_r <= (len == {LEN_W{1'b0}}) ? ST_DONE : ST_FETCH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: state_r <= ST_WAIT;
        ST_WAIT:  state_r <= ST_EMIT;
        ST_EMIT: begin
          if (accept_s && xfer_end_s) begin
            state_r <= ST_DONE;
          end else if (accept_s && word_end_s) begin
            ptr_r   <= ptr_r + ADDR_W'(1);
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_EMIT;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  lcd_word_unpacker #(
    .LEN_W (LEN_W)
  ) u_unpacker (
    .clk        (clk),
    .reset      (reset),
    .init       (init_s),
    .init_len   (len),
    .load       (load_s),
    .load_word  (mem_readdata),
    .char_ready (char_ready),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_last  (char_last),
    .accept     (accept_s),
    .word_end   (word_end_s),
    .xfer_end   (xfer_end_s)
  );

endmodule
